// File: rtl/pattern_pkg.sv
// Shared types and helpers for the pattern editor: repeat FSM states,
// direction bit positions within the move request, and cursor wrap arithmetic.
package pattern_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_t;

   localparam int DIR_UP    = 3;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_RIGHT = 0;

   // Moves pos by delta (-1, 0 or +1) and wraps at both ends of [0, size-1].
   function automatic int wrap_step(input int pos, input int delta, input int size);
      int n;
      n = pos + delta;
      if (n < 0)
         n = size - 1;
      else if (n >= size)
         n = 0;
      return n;
   endfunction

endpackage

// File: rtl/move_repeat.sv
// Turns the level move request into single-edge step pulses with keyboard-style
// auto-repeat: an immediate step, one after REPEAT_DELAY edges, then every REPEAT_RATE.
module move_repeat
   import pattern_pkg::*;
#(
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        move,
   input  logic              lock,
   output logic              step,
   output logic signed [1:0] dx,
   output logic signed [1:0] dy
);

   localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW   = $clog2(CMAX + 1);

   rep_state_t  state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    last_vec, last_vec_n;
   logic [3:0]    vec;

   logic signed [1:0] right_s, left_s, down_s, up_s;

   assign right_s = {1'b0, move[DIR_RIGHT]};
   assign left_s  = {1'b0, move[DIR_LEFT]};
   assign down_s  = {1'b0, move[DIR_DOWN]};
   assign up_s    = {1'b0, move[DIR_UP]};

   // Opposite requests cancel to zero on that axis.
   assign dx  = right_s - left_s;
   assign dy  = down_s - up_s;
   assign vec = {dx, dy};

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         last_vec <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         last_vec <= last_vec_n;
      end
   end

   // cnt holds the number of edges since the last step; it is compared at
   // the edge that would fire the next one.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      last_vec_n = last_vec;
      step       = 1'b0;
      if (lock || vec == 4'd0) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               step       = 1'b1;
               state_n    = ST_DELAY;
               cnt_n      = CW'(1);
               last_vec_n = vec;
            end
            ST_DELAY, ST_REPEAT: begin
               if (vec != last_vec) begin
                  step       = 1'b1;
                  state_n    = ST_DELAY;
                  cnt_n      = CW'(1);
                  last_vec_n = vec;
               end else if ((state == ST_DELAY  && cnt == CW'(REPEAT_DELAY)) ||
                            (state == ST_REPEAT && cnt == CW'(REPEAT_RATE))) begin
                  step    = 1'b1;
                  state_n = ST_REPEAT;
                  cnt_n   = CW'(1);
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            default: begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pattern_editor.sv
// Cursor-driven bit-matrix editor: moves a wrapping cursor, toggles/clears cells,
// and renders the pattern (red) plus a blinking cursor (green). Freezes under lock.
module pattern_editor
   import pattern_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int HEIGHT       = 16,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 4,
   parameter int BLINK_BITS   = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [3:0]                    move,
   input  logic                          toggle,
   input  logic                          clear,
   input  logic                          lock,
   output logic [HEIGHT-1:0][WIDTH-1:0]  pattern,
   output logic [$clog2(WIDTH)-1:0]      cur_x,
   output logic [$clog2(HEIGHT)-1:0]     cur_y,
   output logic [HEIGHT-1:0][WIDTH-1:0]  red_pixels,
   output logic [HEIGHT-1:0][WIDTH-1:0]  grn_pixels
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   logic                  step;
   logic signed [1:0]     step_dx, step_dy;
   logic                  toggle_q;
   logic                  toggle_rise;
   logic [BLINK_BITS-1:0] blink;

   move_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_move_repeat (
      .clk   (clk),
      .reset (reset),
      .move  (move),
      .lock  (lock),
      .step  (step),
      .dx    (step_dx),
      .dy    (step_dy)
   );

   assign toggle_rise = toggle & ~toggle_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_x <= '0;
         cur_y <= '0;
      end else if (step) begin
         cur_x <= XW'(wrap_step(int'(cur_x), int'(step_dx), WIDTH));
         cur_y <= YW'(wrap_step(int'(cur_y), int'(step_dy), HEIGHT));
      end
   end

   // Toggle history keeps sampling under lock so a held toggle never
   // looks like a fresh press when lock drops.
   always_ff @(posedge clk) begin
      if (reset)
         toggle_q <= 1'b0;
      else
         toggle_q <= toggle;
   end

   // The flip uses the registered cursor, i.e. the position before any
   // move taken on the same edge.
   always_ff @(posedge clk) begin
      if (reset)
         pattern <= '0;
      else if (!lock) begin
         if (clear)
            pattern <= '0;
         else if (toggle_rise)
            pattern[cur_y][cur_x] <= ~pattern[cur_y][cur_x];
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         blink <= '0;
      else
         blink <= blink + BLINK_BITS'(1);
   end

   assign red_pixels = pattern;

   always_comb begin
      grn_pixels = '0;
      if (!lock && !blink[BLINK_BITS-1])
         grn_pixels[cur_y][cur_x] = 1'b1;
   end

endmodule

// File: tb/tb_pattern_editor.sv
// Directed bench for pattern_editor at default parameters (16x16, delay 16, rate 4).
module tb_pattern_editor;

   logic                clk = 1'b0;
   logic                reset;
   logic [3:0]          move;
   logic                toggle;
   logic                clear;
   logic                lock;
   logic [15:0][15:0]   pattern;
   logic [3:0]          cur_x;
   logic [3:0]          cur_y;
   logic [15:0][15:0]   red_pixels;
   logic [15:0][15:0]   grn_pixels;

   int checks = 0;
   int errors = 0;

   logic [15:0][15:0] exp_pat;
   logic [15:0][15:0] exp_grn;
   logic [7:0]        exp_cur;

   pattern_editor dut (
      .clk        (clk),
      .reset      (reset),
      .move       (move),
      .toggle     (toggle),
      .clear      (clear),
      .lock       (lock),
      .pattern    (pattern),
      .cur_x      (cur_x),
      .cur_y      (cur_y),
      .red_pixels (red_pixels),
      .grn_pixels (grn_pixels)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_move(input logic [3:0] m);
      move = m;
      tick();
      move = 4'b0000;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; move = 4'b0000; toggle = 1'b0; clear = 1'b0; lock = 1'b0;
      tick();
      tick();
      checks++;
      if ({cur_y, cur_x} !== 8'h00) begin
         errors++; $display("FAIL reset_cursor: got y,x=%h expected 00", {cur_y, cur_x});
      end
      checks++;
      if (pattern !== '0) begin
         errors++; $display("FAIL reset_pattern: got %h expected 0", pattern);
      end
      checks++;
      if (red_pixels !== '0) begin
         errors++; $display("FAIL reset_red: got %h expected 0", red_pixels);
      end
      exp_grn = '0; exp_grn[0][0] = 1'b1;
      checks++;
      if (grn_pixels !== exp_grn) begin
         errors++; $display("FAIL reset_grn: got %h expected %h", grn_pixels, exp_grn);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_step();
      move = 4'b0001;
      tick();
      checks++;
      if ({cur_y, cur_x} !== 8'h01) begin
         errors++; $display("FAIL single_step: got y,x=%h expected 01", {cur_y, cur_x});
      end
      move = 4'b0000;
      tick(); tick(); tick();
      checks++;
      if ({cur_y, cur_x} !== 8'h01) begin
         errors++; $display("FAIL single_step_hold: got y,x=%h expected 01", {cur_y, cur_x});
      end
   endtask

   task automatic test_repeat_wrap();
      for (int i = 0; i < 13; i++) pulse_move(4'b0001);
      checks++;
      if ({cur_y, cur_x} !== 8'h0E) begin
         errors++; $display("FAIL repeat_setup: got y,x=%h expected 0e", {cur_y, cur_x});
      end
      move = 4'b0001;
      tick();                                   // edge 0
      checks++;
      if (cur_x !== 4'd15) begin
         errors++; $display("FAIL repeat_edge0: got x=%0d expected 15", cur_x);
      end
      for (int i = 1; i <= 15; i++) tick();     // edges 1..15
      checks++;
      if (cur_x !== 4'd15) begin
         errors++; $display("FAIL repeat_edge15: got x=%0d expected 15", cur_x);
      end
      tick();                                   // edge 16
      checks++;
      if (cur_x !== 4'd0) begin
         errors++; $display("FAIL repeat_edge16_wrap: got x=%0d expected 0", cur_x);
      end
      tick(); tick(); tick();                   // edges 17..19
      checks++;
      if (cur_x !== 4'd0) begin
         errors++; $display("FAIL repeat_edge19: got x=%0d expected 0", cur_x);
      end
      tick();                                   // edge 20
      checks++;
      if (cur_x !== 4'd1) begin
         errors++; $display("FAIL repeat_edge20: got x=%0d expected 1", cur_x);
      end
      move = 4'b0000;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if ({cur_y, cur_x} !== 8'h01) begin
         errors++; $display("FAIL repeat_release: got y,x=%h expected 01", {cur_y, cur_x});
      end
   endtask

   task automatic test_toggle();
      pulse_move(4'b0001); pulse_move(4'b0001);
      pulse_move(4'b0100); pulse_move(4'b0100);
      checks++;
      if ({cur_y, cur_x} !== 8'h23) begin
         errors++; $display("FAIL toggle_setup: got y,x=%h expected 23", {cur_y, cur_x});
      end
      toggle = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      exp_pat = '0; exp_pat[2][3] = 1'b1;
      checks++;
      if (pattern !== exp_pat) begin
         errors++; $display("FAIL toggle_held_once: got %h expected %h", pattern, exp_pat);
      end
      checks++;
      if (red_pixels !== exp_pat) begin
         errors++; $display("FAIL toggle_red: got %h expected %h", red_pixels, exp_pat);
      end
      toggle = 1'b0; tick();
      toggle = 1'b1; tick();
      checks++;
      if (pattern !== '0) begin
         errors++; $display("FAIL toggle_second: got %h expected 0", pattern);
      end
      toggle = 1'b0; tick();
   endtask

   task automatic test_cancel();
      move = 4'b1100; tick(); tick();
      checks++;
      if ({cur_y, cur_x} !== 8'h23) begin
         errors++; $display("FAIL cancel_updown: got y,x=%h expected 23", {cur_y, cur_x});
      end
      move = 4'b0011; tick(); tick();
      checks++;
      if ({cur_y, cur_x} !== 8'h23) begin
         errors++; $display("FAIL cancel_leftright: got y,x=%h expected 23", {cur_y, cur_x});
      end
      move = 4'b0000;
      reset = 1'b1; tick(); reset = 1'b0;
      move = 4'b1001; tick();
      checks++;
      if ({cur_y, cur_x} !== 8'hF1) begin
         errors++; $display("FAIL diagonal_wrap: got y,x=%h expected f1", {cur_y, cur_x});
      end
      move = 4'b0000; tick();
   endtask

   task automatic test_clear();
      toggle = 1'b1; tick(); toggle = 1'b0; tick();
      exp_pat = '0; exp_pat[15][1] = 1'b1;
      checks++;
      if (pattern !== exp_pat) begin
         errors++; $display("FAIL clear_setup: got %h expected %h", pattern, exp_pat);
      end
      pulse_move(4'b0001);
      toggle = 1'b1; clear = 1'b1; tick();
      checks++;
      if (pattern !== '0) begin
         errors++; $display("FAIL clear_over_toggle: got %h expected 0", pattern);
      end
      checks++;
      if ({cur_y, cur_x} !== 8'hF2) begin
         errors++; $display("FAIL clear_cursor: got y,x=%h expected f2", {cur_y, cur_x});
      end
      toggle = 1'b0; clear = 1'b0; tick();
   endtask

   task automatic test_lock();
      toggle = 1'b1; tick(); toggle = 1'b0; tick();
      exp_pat = '0; exp_pat[15][2] = 1'b1;
      lock = 1'b1; move = 4'b0001; toggle = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if ({cur_y, cur_x} !== 8'hF2) begin
         errors++; $display("FAIL lock_cursor: got y,x=%h expected f2", {cur_y, cur_x});
      end
      checks++;
      if (pattern !== exp_pat) begin
         errors++; $display("FAIL lock_pattern: got %h expected %h", pattern, exp_pat);
      end
      checks++;
      if (grn_pixels !== '0) begin
         errors++; $display("FAIL lock_grn: got %h expected 0", grn_pixels);
      end
      clear = 1'b1; tick(); clear = 1'b0;
      checks++;
      if (pattern !== exp_pat) begin
         errors++; $display("FAIL lock_clear: got %h expected %h", pattern, exp_pat);
      end
      move = 4'b0000; lock = 1'b0;
      tick(); tick();
      checks++;
      if (pattern !== exp_pat) begin
         errors++; $display("FAIL unlock_held_toggle: got %h expected %h", pattern, exp_pat);
      end
      checks++;
      if ({cur_y, cur_x} !== 8'hF2) begin
         errors++; $display("FAIL unlock_cursor: got y,x=%h expected f2", {cur_y, cur_x});
      end
      toggle = 1'b0; tick();
   endtask

   task automatic test_blink();
      int shown;
      shown = 0;
      exp_grn = '0; exp_grn[15][2] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (grn_pixels !== '0) begin
            shown++;
            checks++;
            if (grn_pixels !== exp_grn) begin
               errors++; $display("FAIL blink_onehot: got %h expected %h", grn_pixels, exp_grn);
            end
         end
      end
      checks++;
      if (shown !== 4) begin
         errors++; $display("FAIL blink_duty: got %0d of 8 cycles expected 4", shown);
      end
   endtask

   task automatic test_dir_change();
      reset = 1'b1; move = 4'b0001; tick(); tick();
      checks++;
      if ({cur_y, cur_x} !== 8'h00) begin
         errors++; $display("FAIL reset_overrides_move: got y,x=%h expected 00", {cur_y, cur_x});
      end
      reset = 1'b0; tick();                     // first post-reset edge
      checks++;
      if ({cur_y, cur_x} !== 8'h01) begin
         errors++; $display("FAIL post_reset_step: got y,x=%h expected 01", {cur_y, cur_x});
      end
      for (int i = 0; i < 4; i++) tick();
      move = 4'b0100; tick();                   // direction change: immediate step
      checks++;
      if ({cur_y, cur_x} !== 8'h11) begin
         errors++; $display("FAIL dir_change_step: got y,x=%h expected 11", {cur_y, cur_x});
      end
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if ({cur_y, cur_x} !== 8'h11) begin
         errors++; $display("FAIL dir_change_delay: got y,x=%h expected 11", {cur_y, cur_x});
      end
      tick();
      checks++;
      if ({cur_y, cur_x} !== 8'h21) begin
         errors++; $display("FAIL dir_change_repeat: got y,x=%h expected 21", {cur_y, cur_x});
      end
      move = 4'b0000; tick();
   endtask

   initial begin
      reset = 1'b1; move = 4'b0000; toggle = 1'b0; clear = 1'b0; lock = 1'b0;
      test_reset();
      test_single_step();
      test_repeat_wrap();
      test_toggle();
      test_cancel();
      test_clear();
      test_lock();
      test_blink();
      test_dir_change();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_editor.md
PATTERN_EDITOR -- requirements
Module: pattern_editor

Interface
REQ-001 SHALL have parameter WIDTH, 16, matrix columns (>=2, non-power-of-two legal).
REQ-002 SHALL have parameter HEIGHT, 16, matrix rows (>=2, non-power-of-two legal).
REQ-003 SHALL have parameter REPEAT_DELAY, 16, edges between first step and first auto-repeat step (>=2).
REQ-004 SHALL have parameter REPEAT_RATE, 4, edges between subsequent auto-repeat steps (>=1).
REQ-005 SHALL have parameter BLINK_BITS, 3, cursor blink counter width.
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port move  input  4  level direction request {up,down,left,right}.
REQ-009 SHALL have port toggle  input  1  flip cell under cursor (rising-edge detected).
REQ-010 SHALL have port clear  input  1  clear whole pattern (level).
REQ-011 SHALL have port lock  input  1  freeze editing while simulation runs.
REQ-012 SHALL have port pattern  output  HEIGHT x WIDTH  registered cell state, [row][col].
REQ-013 SHALL have ports cur_x / cur_y  output  $clog2(WIDTH) / $clog2(HEIGHT)  registered cursor, row 0 top.
REQ-014 SHALL have port red_pixels  output  HEIGHT x WIDTH  combinational copy of pattern.
REQ-015 SHALL have port grn_pixels  output  HEIGHT x WIDTH  one-hot cursor at [cur_y][cur_x] while blink MSB=0, else all-zero.

Function
REQ-016 SHALL decode dx = right - left, dy = down - up; opposite pairs cancel; diagonals step both axes.
REQ-017 SHALL wrap: x WIDTH-1 +1 -> 0, x 0 -1 -> WIDTH-1; same for y with HEIGHT.
REQ-018 SHALL run FSM IDLE/DELAY/REPEAT on decoded vector v: IDLE & v!=0 -> step, DELAY; v==0 in any state -> IDLE, no step.
REQ-019 SHALL, in DELAY with v unchanged, count so the step occurs exactly REPEAT_DELAY edges after the first, then enter REPEAT.
REQ-020 SHALL, in REPEAT with v unchanged, step every REPEAT_RATE edges.
REQ-021 SHALL, in DELAY/REPEAT when v changes to another nonzero value, step immediately in the new direction and re-enter DELAY.
REQ-022 SHALL show the cursor update the cycle after the edge that samples the step (1-cycle latency).
REQ-023 SHALL, on toggle rising edge, flip pattern[cur_y][cur_x] using the pre-move cursor when a move occurs on the same edge.
REQ-024 SHALL zero pattern on any edge with clear=1; clear overrides same-cycle toggle; cursor unaffected.
REQ-025 SHALL, while lock=1, ignore move/toggle/clear, force FSM IDLE, hold cursor and pattern, drive grn_pixels all-zero.
REQ-026 SHALL keep sampling toggle history during lock so a toggle held across lock deassert does not flip.
REQ-027 SHALL free-run the blink counter, incrementing every edge and wrapping.

Reset
REQ-028 SHALL on reset set pattern=0, cur_x=cur_y=0, FSM IDLE, repeat and blink counters 0, toggle history 0.
REQ-029 SHALL override all inputs with reset; move held through reset release is treated as a fresh press (step on first post-reset edge).

Structure
REQ-030 SHALL place FSM state enum and direction bit-index constants (UP=3, DOWN=2, LEFT=1, RIGHT=0) in package pattern_pkg.
REQ-031 SHALL implement decode, FSM and repeat counter in sub-module move_repeat emitting a one-cycle step pulse with dx/dy.

Verification
REQ-032 SHALL cover: reset, move=0001 for one edge -> cur=(1,0) next cycle, no further step.
REQ-033 SHALL cover: WIDTH=16, hold move=0001 from x=14 -> steps at edges 0,16,20 -> x=15,0,1 (wrap).
REQ-034 SHALL cover: toggle held 10 cycles at (3,2) -> pattern[2][3]=1 once; second pulse -> 0.
REQ-035 SHALL cover: move=1100 or 0011 -> no step; move=1001 from (0,0) -> (1,HEIGHT-1).
REQ-036 SHALL cover: clear and toggle same edge with nonzero pattern -> pattern all-zero.
REQ-037 SHALL cover: lock=1 with move/toggle -> cursor, pattern unchanged, grn_pixels=0; lock->0 with toggle still high -> no flip.
